// File: rtl/video_pkg.sv
// Shared video-path definitions.
//   PIX_W     : RGB pixel width in bits
//   DMA_W     : wide DMA beat width in bits
//   cnt_width : width of a counter able to hold 0..buf_w inclusive
package video_pkg;

  localparam int PIX_W = 24;
  localparam int DMA_W = 256;

  function automatic int cnt_width(input int buf_w);
    return $clog2(buf_w + 1);
  endfunction

endpackage

// File: rtl/gearbox_wide_to_narrow_if.sv
// Stream bundle for the wide-to-narrow gearbox.
//   in_data/in_valid/in_last/in_ready     : wide input stream
//   out_data/out_valid/out_last/out_ready : narrow output stream
//   slave  : gearbox side (consumes input stream, produces output stream)
//   master : environment side (produces input stream, consumes output stream)
interface gearbox_wide_to_narrow_if
  import video_pkg::*;
#(
  parameter int IN_W  = DMA_W,
  parameter int OUT_W = PIX_W
);

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/gearbox_wide_to_narrow.sv
// Packs wide IN_W-bit words into a continuous stream of OUT_W-bit words.
// Residue bits carry across input words; in_last flushes a final word,
// zero-padded above the remaining valid bits.
//   clock : block clock
//   rst_n : asynchronous active-low reset
//   bus   : stream bundle (slave modport), bit 0 of each word is oldest
//   idle  : buffer empty and no flush pending
module gearbox_wide_to_narrow
  import video_pkg::*;
#(
  parameter int IN_W  = DMA_W,
  parameter int OUT_W = PIX_W
) (
  input  logic                    clock,
  input  logic                    rst_n,
  gearbox_wide_to_narrow_if.slave bus,
  output logic                    idle
);

  localparam int BUF_W = IN_W + OUT_W;
  localparam int CNT_W = cnt_width(BUF_W);

  localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] IN_CNT  = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] BUF_CNT = CNT_W'(BUF_W);

  logic [BUF_W-1:0] bit_buf;
  logic [BUF_W-1:0] buf_popped;
  logic [BUF_W-1:0] buf_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_popped;
  logic [CNT_W-1:0] cnt_next;
  logic             flush_pend;

  logic out_valid_c;
  logic out_last_c;
  logic out_fire;
  logic in_ready_c;
  logic in_fire;

  always_comb begin
    out_valid_c = (cnt >= OUT_CNT) || (flush_pend && (cnt != '0));
    out_last_c  = out_valid_c && flush_pend && (cnt <= OUT_CNT);
    out_fire    = out_valid_c && bus.out_ready;

    // Pop first so the push lands at the post-pop offset; this lets a new
    // word enter in the same cycle the buffer drains to <= OUT_W bits.
    buf_popped = bit_buf;
    cnt_popped = cnt;
    if (out_fire) begin
      buf_popped = bit_buf >> OUT_W;
      cnt_popped = (cnt >= OUT_CNT) ? cnt - OUT_CNT : '0;
    end

    // cnt_popped <= OUT_W guarantees cnt_popped + IN_W <= BUF_W.
    in_ready_c = !flush_pend && (cnt_popped <= OUT_CNT);
    in_fire    = bus.in_valid && in_ready_c;

    buf_next = buf_popped;
    cnt_next = cnt_popped;
    if (in_fire) begin
      buf_next = buf_popped | (BUF_W'(bus.in_data) << cnt_popped);
      cnt_next = cnt_popped + IN_CNT;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bit_buf    <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      bit_buf <= buf_next;
      cnt     <= cnt_next;
      if (in_fire && bus.in_last) begin
        flush_pend <= 1'b1;
      end else if (out_fire && out_last_c) begin
        flush_pend <= 1'b0;
      end
      assert (cnt_next <= BUF_CNT);
      assert (!(in_fire && flush_pend));
    end
  end

  assign bus.out_data  = bit_buf[OUT_W-1:0];
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.in_ready  = in_ready_c;
  assign idle          = (cnt == '0) && !flush_pend;

endmodule

// File: tb/tb_gearbox_wide_to_narrow.sv
module tb_gearbox_wide_to_narrow;
  import video_pkg::*;

  localparam int IN_W  = DMA_W;
  localparam int OUT_W = PIX_W;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic idle;

  int n_pass  = 0;
  int n_total = 0;

  gearbox_wide_to_narrow_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  gearbox_wide_to_narrow #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus),
    .idle  (idle)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Word w of a ramp stream: byte i holds w*32+i.
  function automatic logic [IN_W-1:0] ramp_word(input int w);
    logic [IN_W-1:0] r;
    for (int i = 0; i < IN_W / 8; i++) r[i*8 +: 8] = 8'(w * (IN_W / 8) + i);
    return r;
  endfunction

  // Output word k of a ramp stream of n_bytes bytes; bytes past the end are zero padding.
  function automatic logic [OUT_W-1:0] exp_pix(input int k, input int n_bytes);
    logic [OUT_W-1:0] r;
    for (int b = 0; b < 3; b++) begin
      int j;
      j = 3 * k + b;
      r[b*8 +: 8] = (j < n_bytes) ? 8'(j) : 8'h00;
    end
    return r;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_in_ready"},  64'(bus.in_ready),  64'd1);
    check({pfx, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({pfx, "_out_last"},  64'(bus.out_last),  64'd0);
    check({pfx, "_out_data"},  64'(bus.out_data),  64'd0);
    check({pfx, "_idle"},      64'(idle),          64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Streams n_words ramp words and checks every output word against the ramp model.
  // stop_at != 0 returns right after the stop_at-th output is observed (before it pops).
  task automatic run_frame(input int n_words, input bit last, input bit stall,
                           input int exp_outs, input int stop_at);
    int sent = 0;
    int got = 0;
    int extra_cyc = 0;
    bit prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < n_words) begin
        bus.in_valid = 1'b1;
        bus.in_data  = ramp_word(sent);
        bus.in_last  = last && (sent == n_words - 1);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
      end
      #1;
      if (prev_stall) begin
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_data",  64'(bus.out_data),  64'(prev_data));
        check("stall_last",  64'(bus.out_last),  64'(prev_last));
      end
      if (last && sent == n_words && got < exp_outs)
        check("flush_in_ready", 64'(bus.in_ready), 64'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (got < exp_outs) begin
          check($sformatf("data_%0d", got), 64'(bus.out_data), 64'(exp_pix(got, n_words * (IN_W / 8))));
          check($sformatf("last_%0d", got), 64'(bus.out_last), 64'(last && got == exp_outs - 1));
        end else begin
          check("extra_output", 64'(got + 1), 64'(exp_outs));
        end
        got++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      if (bus.in_valid && bus.in_ready) sent++;
      if (stop_at != 0 && got == stop_at) break;
      if (sent == n_words && got >= exp_outs) extra_cyc++;
      if (extra_cyc > 4) break;
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    if (stop_at == 0) check("out_count", 64'(got), 64'(exp_outs));
    else              check("stop_count", 64'(got), 64'(stop_at));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Outputs while held in reset.
    #12;
    check_reset_outputs("rst");
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    check_reset_outputs("post_rst");

    // Single word without last: 10 outputs, 16 residue bits stay buffered.
    run_frame(1, 1'b0, 1'b0, 10, 0);
    check("single_cnt", 64'(dut.cnt), 64'd16);
    check("single_idle", 64'(idle), 64'd0);
    check("single_valid", 64'(bus.out_valid), 64'd0);
    do_reset();

    // Three back-to-back words: 32 outputs, buffer fully drained.
    run_frame(3, 1'b0, 1'b0, 32, 0);
    check("three_cnt", 64'(dut.cnt), 64'd0);
    check("three_idle", 64'(idle), 64'd1);
    do_reset();

    // Single word with last: 11 outputs, 11th is 0x001F1E with out_last.
    run_frame(1, 1'b1, 1'b0, 11, 0);
    check("flush_idle", 64'(idle), 64'd1);
    check("flush_in_ready_after", 64'(bus.in_ready), 64'd1);
    do_reset();

    // Random backpressure over three words.
    run_frame(3, 1'b0, 1'b1, 32, 0);
    check("stall_idle", 64'(idle), 64'd1);
    do_reset();

    // Last on an exact multiple of OUT_W: no padding word.
    run_frame(3, 1'b1, 1'b0, 32, 0);
    check("exact_idle", 64'(idle), 64'd1);
    do_reset();

    // Asynchronous reset mid-frame after 5 outputs.
    bus.out_ready = 1'b1;
    run_frame(1, 1'b0, 1'b0, 10, 5);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    #2;
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    run_frame(1, 1'b0, 1'b0, 10, 0);
    check("mid_rst_cnt", 64'(dut.cnt), 64'd16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
